// File: rtl/ifu_ialign_pkg.sv
// Shared types and helpers for the instruction aligner: halfword queue entry
// and the 32-bit opcode test used by head decode.
package ifu_ialign_pkg;

  typedef struct packed {
    logic [15:0] hw;
    logic        err;
  } ialign_hw_t;

  localparam logic [1:0] RVC_OPC_32 = 2'b11;

  function automatic logic is_rvc32(input logic [15:0] hw);
    return hw[1:0] == RVC_OPC_32;
  endfunction

endpackage

// File: rtl/ifu_ialign_hwq.sv
// Circular halfword queue: pushes 0..2 halfwords and pops 0..2 halfwords per
// cycle, exposing the two oldest entries and the occupancy count.
module ifu_ialign_hwq
  import ifu_ialign_pkg::*;
#(
  parameter  int QDEPTH = 6,
  localparam int PW     = $clog2(QDEPTH),
  localparam int CW     = $clog2(QDEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_l,
  input  logic          clr,
  input  logic [1:0]    push_n,
  input  ialign_hw_t    push0,
  input  ialign_hw_t    push1,
  input  logic [1:0]    pop_n,
  output ialign_hw_t    head0,
  output ialign_hw_t    head1,
  output logic [CW-1:0] count
);

  logic [PW-1:0] rd_ptr, wr_ptr, rd_ptr1, wr_ptr1;
  ialign_hw_t    mem [QDEPTH];

  function automatic logic [PW-1:0] adv(input logic [PW-1:0] p, input logic [1:0] n);
    logic [PW:0] s;
    s = {1'b0, p} + (PW+1)'(n);
    if (s >= (PW+1)'(QDEPTH)) s = s - (PW+1)'(QDEPTH);
    return s[PW-1:0];
  endfunction

  assign rd_ptr1 = adv(rd_ptr, 2'd1);
  assign wr_ptr1 = adv(wr_ptr, 2'd1);
  assign head0   = mem[rd_ptr];
  assign head1   = mem[rd_ptr1];

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < QDEPTH; i++) mem[i] <= '0;
    end else if (!clr) begin
      if (push_n != 2'd0) mem[wr_ptr]  <= push0;
      if (push_n == 2'd2) mem[wr_ptr1] <= push1;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= adv(rd_ptr, pop_n);
      wr_ptr <= adv(wr_ptr, push_n);
      count  <= count + CW'(push_n) - CW'(pop_n);
    end
  end

endmodule

// File: rtl/ifu_ialign_ctl.sv
// Halfword instruction aligner: buffers fetch words, emits one RVC or 32-bit
// instruction per cycle with PC/error tracking. IALIGN_BYPASS_EN adds a
// zero-latency fetch->instruction path when the queue is empty.
module ifu_ialign_ctl
  import ifu_ialign_pkg::*;
#(
  parameter int QDEPTH = 6,
  parameter int PCW    = 31
) (
  input  logic           clk,
  input  logic           rst_l,
  input  logic           flush,
  input  logic [PCW-1:0] flush_pc,
  input  logic           fetch_valid,
  input  logic [31:0]    fetch_data,
  input  logic           fetch_err,
  output logic           fetch_ready,
  output logic           ins_valid,
  input  logic           ins_ready,
  output logic [31:0]    ins_data,
  output logic           ins_is16,
  output logic [PCW-1:0] ins_pc,
  output logic           ins_err
);

  localparam int CW = $clog2(QDEPTH + 1);

  logic [PCW-1:0] pc;
  logic           drop_lo;
  logic [CW-1:0]  count;
  ialign_hw_t     q0, q1, hd0, hd1, w_lo, w_hi, push0, push1;
  logic [1:0]     avail, use_n, skip, push_n, pop_n;
  logic           accept, byp, h32, take2, fire;

  assign w_lo = {fetch_data[15:0],  fetch_err};
  assign w_hi = {fetch_data[31:16], fetch_err};

  // Registered count only, so downstream ready never reaches fetch_ready.
  assign fetch_ready = !flush && (count <= CW'(QDEPTH - 2));
  assign accept      = fetch_valid && fetch_ready;

`ifdef IALIGN_BYPASS_EN
  assign byp = (count == '0) && accept;
`else
  assign byp = 1'b0;
`endif

  // Head source: queue normally, the incoming word when bypassing.
  always_comb begin
    hd0   = q0;
    hd1   = q1;
    avail = (count == '0) ? 2'd0 : (count == CW'(1)) ? 2'd1 : 2'd2;
    if (byp) begin
      hd0   = drop_lo ? w_hi : w_lo;
      hd1   = w_hi;
      avail = drop_lo ? 2'd1 : 2'd2;
    end
  end

  assign h32   = is_rvc32(hd0.hw);
  assign take2 = h32 && (avail == 2'd2);
  // A lone 32-bit head with an error is emitted alone so faults never stall.
  assign ins_valid = !flush && (avail != 2'd0) && (!h32 || take2 || hd0.err);
  assign fire      = ins_valid && ins_ready;
  assign use_n     = take2 ? 2'd2 : 2'd1;

  assign ins_is16 = ins_valid && !h32;
  assign ins_data = !ins_valid ? 32'h0 :
                    take2      ? {hd1.hw, hd0.hw} : {16'h0, hd0.hw};
  assign ins_err  = ins_valid && (hd0.err || (take2 && hd1.err));
  assign ins_pc   = pc;

  // Halfwords of the incoming word skipped: dropped odd start plus any bypassed.
  assign skip   = {1'b0, drop_lo} + ((byp && fire) ? use_n : 2'd0);
  assign push_n = accept ? (2'd2 - skip) : 2'd0;
  assign push0  = (skip == 2'd0) ? w_lo : w_hi;
  assign push1  = w_hi;
  assign pop_n  = (fire && !byp) ? use_n : 2'd0;

  ifu_ialign_hwq #(.QDEPTH(QDEPTH)) u_hwq (
    .clk    (clk),
    .rst_l  (rst_l),
    .clr    (flush),
    .push_n (push_n),
    .push0  (push0),
    .push1  (push1),
    .pop_n  (pop_n),
    .head0  (q0),
    .head1  (q1),
    .count  (count)
  );

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      pc      <= '0;
      drop_lo <= 1'b0;
    end else if (flush) begin
      pc      <= flush_pc;
      drop_lo <= flush_pc[0];
    end else begin
      if (fire)   pc      <= pc + PCW'(use_n);
      if (accept) drop_lo <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ifu_ialign_ctl.sv
// Aligner bench: directed scenarios plus random traffic, all checked every
// cycle against a halfword-queue reference model.
module tb_ifu_ialign_ctl;
  import ifu_ialign_pkg::*;

  localparam int QDEPTH = 6;
  localparam int PCW    = 31;

  logic           clk = 1'b0;
  logic           rst_l = 1'b0;
  logic           flush = 1'b0;
  logic [PCW-1:0] flush_pc = '0;
  logic           fetch_valid = 1'b0;
  logic [31:0]    fetch_data = '0;
  logic           fetch_err = 1'b0;
  logic           fetch_ready;
  logic           ins_valid;
  logic           ins_ready = 1'b0;
  logic [31:0]    ins_data;
  logic           ins_is16;
  logic [PCW-1:0] ins_pc;
  logic           ins_err;

  int checks = 0;
  int errors = 0;

  ialign_hw_t     mq[$];
  logic [PCW-1:0] m_pc;
  logic           m_drop;

  ifu_ialign_ctl #(.QDEPTH(QDEPTH), .PCW(PCW)) dut (
    .clk         (clk),
    .rst_l       (rst_l),
    .flush       (flush),
    .flush_pc    (flush_pc),
    .fetch_valid (fetch_valid),
    .fetch_data  (fetch_data),
    .fetch_err   (fetch_err),
    .fetch_ready (fetch_ready),
    .ins_valid   (ins_valid),
    .ins_ready   (ins_ready),
    .ins_data    (ins_data),
    .ins_is16    (ins_is16),
    .ins_pc      (ins_pc),
    .ins_err     (ins_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h @%0t", tag, act, exp, $time);
    end
  endtask

  // Predict outputs from the model queue, compare, then advance the model.
  task automatic model_cycle();
    bit          e_rdy, e_vld, e16, eerr;
    logic [31:0] e_data;
    int          n;
    e_rdy = !flush && (mq.size() <= QDEPTH - 2);
    e_vld = 0; e16 = 0; eerr = 0; e_data = '0; n = 0;
    if (!flush && mq.size() > 0) begin
      if (mq[0].hw[1:0] != 2'b11) begin
        e_vld = 1; e16 = 1; n = 1; e_data = {16'h0, mq[0].hw}; eerr = mq[0].err;
      end else if (mq.size() >= 2) begin
        e_vld = 1; n = 2; e_data = {mq[1].hw, mq[0].hw}; eerr = mq[0].err | mq[1].err;
      end else if (mq[0].err) begin
        e_vld = 1; n = 1; e_data = {16'h0, mq[0].hw}; eerr = 1;
      end
    end
    chk("fetch_ready", {31'h0, fetch_ready}, {31'h0, e_rdy});
    chk("ins_valid", {31'h0, ins_valid}, {31'h0, e_vld});
    chk("ins_pc", {1'b0, ins_pc}, {1'b0, m_pc});
    if (e_vld) begin
      chk("ins_data", ins_data, e_data);
      chk("ins_is16", {31'h0, ins_is16}, {31'h0, e16});
      chk("ins_err", {31'h0, ins_err}, {31'h0, eerr});
    end
    if (flush) begin
      mq.delete();
      m_pc   = flush_pc;
      m_drop = flush_pc[0];
    end else begin
      if (e_vld && ins_ready) begin
        repeat (n) void'(mq.pop_front());
        m_pc = m_pc + PCW'(n);
      end
      if (fetch_valid && e_rdy) begin
        if (!m_drop) mq.push_back({fetch_data[15:0], fetch_err});
        mq.push_back({fetch_data[31:16], fetch_err});
        m_drop = 0;
      end
    end
  endtask

  task automatic step(input logic f, input logic [PCW-1:0] fpc, input logic fv,
                      input logic [31:0] fd, input logic fe, input logic rdy);
    @(posedge clk);
    #1;
    flush = f; flush_pc = fpc; fetch_valid = fv; fetch_data = fd;
    fetch_err = fe; ins_ready = rdy;
    @(negedge clk);
    model_cycle();
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, '0, 1'b0, 32'h0, 1'b0, rdy);
  endtask

  function automatic logic [15:0] rand_hw();
    logic [15:0] h;
    h = 16'($urandom);
    if ($urandom_range(0, 2) == 0) h[1:0] = 2'b11;
    return h;
  endfunction

  initial begin
    mq.delete(); m_pc = '0; m_drop = 1'b0;
    #3;
    chk("rst_fetch_ready", {31'h0, fetch_ready}, 32'h1);
    chk("rst_ins_valid", {31'h0, ins_valid}, 32'h0);
    chk("rst_ins_data", ins_data, 32'h0);
    chk("rst_ins_is16", {31'h0, ins_is16}, 32'h0);
    chk("rst_ins_pc", {1'b0, ins_pc}, 32'h0);
    chk("rst_ins_err", {31'h0, ins_err}, 32'h0);
    @(negedge clk);
    rst_l = 1'b1;

    // 32-bit aligned instruction, one-cycle latency; flush-cycle fetch is refused
    step(1'b1, 31'h20, 1'b1, 32'hdeadbeef, 1'b0, 1'b1);
    chk("flush_refuses_fetch", {31'h0, fetch_ready}, 32'h0);
    step(1'b0, '0, 1'b1, 32'h00010513, 1'b0, 1'b1);
    chk("t1_latency", {31'h0, ins_valid}, 32'h0);
    idle(1'b1);
    chk("t1_data", ins_data, 32'h00010513);
    chk("t1_pc", {1'b0, ins_pc}, 32'h20);
    idle(1'b1);
    chk("t1_drained", {31'h0, ins_valid}, 32'h0);

    // two compressed instructions in one word
    step(1'b1, 31'h20, 1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 32'h45014501, 1'b0, 1'b1);
    idle(1'b1);
    chk("t2_first", ins_data, 32'h00004501);
    idle(1'b1);
    chk("t2_second_pc", {1'b0, ins_pc}, 32'h21);
    chk("t2_second_is16", {31'h0, ins_is16}, 32'h1);

    // straddling 32-bit instruction
    step(1'b1, 31'h20, 1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 32'h05134501, 1'b0, 1'b1);
    idle(1'b1);
    step(1'b0, '0, 1'b1, 32'h45010001, 1'b0, 1'b1);
    chk("t3_wait_upper", {31'h0, ins_valid}, 32'h0);
    idle(1'b1);
    chk("t3_straddle", ins_data, 32'h00010513);
    chk("t3_straddle_pc", {1'b0, ins_pc}, 32'h21);
    idle(1'b1);
    chk("t3_tail_pc", {1'b0, ins_pc}, 32'h23);

    // odd flush target drops the low halfword
    step(1'b1, 31'h31, 1'b1, 32'h11111111, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 32'h45020000, 1'b0, 1'b1);
    idle(1'b1);
    chk("t4_odd_start", ins_data, 32'h00004502);
    chk("t4_odd_pc", {1'b0, ins_pc}, 32'h31);

    // lone erroneous 32-bit head, then straddle with error on the second word
    step(1'b1, 31'h21, 1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 32'h05130000, 1'b1, 1'b1);
    idle(1'b1);
    chk("t5_lone_err", {31'h0, ins_err}, 32'h1);
    chk("t5_lone_data", ins_data, 32'h00000513);
    step(1'b1, 31'h21, 1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 32'h05130000, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 32'h45010001, 1'b1, 1'b1);
    idle(1'b1);
    chk("t5_straddle_err", {31'h0, ins_err}, 32'h1);

    // backpressure fills the queue, then drain in order
    step(1'b1, 31'h20, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, '0, 1'b1, {16'h6000 + 16'(i << 2), 16'h4000 + 16'(i << 2)}, 1'b0, 1'b0);
      if (i == 4) chk("t6_full", {31'h0, fetch_ready}, 32'h0);
    end
    idle(1'b1);
    chk("t6_first_out", ins_data, 32'h00004000);
    for (int i = 0; i < 7; i++) idle(1'b1);

    // random traffic with occasional flush and one mid-run reset
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        @(posedge clk);
        #2;
        flush = 1'b0; fetch_valid = 1'b0; rst_l = 1'b0;
        #1;
        chk("mid_rst_valid", {31'h0, ins_valid}, 32'h0);
        chk("mid_rst_ready", {31'h0, fetch_ready}, 32'h1);
        chk("mid_rst_pc", {1'b0, ins_pc}, 32'h0);
        mq.delete(); m_pc = '0; m_drop = 1'b0;
        @(negedge clk);
        rst_l = 1'b1;
      end
      step(($urandom_range(0, 40) == 0), PCW'($urandom),
           ($urandom_range(0, 3) != 0), {rand_hw(), rand_hw()},
           ($urandom_range(0, 12) == 0), ($urandom_range(0, 9) < 7));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
